// File: rtl/sprite_palette_bank_if.sv
// sprite_palette_bank_if: pixel lookup and palette write bus between pixel fetchers and the palette.
interface sprite_palette_bank_if #(
    parameter int INDEX_W = 4,
    parameter int CHAN_W = 4,
    parameter int BANKS = 4
);
    localparam int BANK_W = BANKS > 1 ? $clog2(BANKS) : 1;
    logic wr_en;
    logic [BANK_W-1:0] wr_bank;
    logic [INDEX_W-1:0] wr_index;
    logic [3*CHAN_W-1:0] wr_rgb;
    logic pix_valid_i;
    logic [INDEX_W-1:0] pix_index_i;
    logic [CHAN_W-1:0] red;
    logic [CHAN_W-1:0] green;
    logic [CHAN_W-1:0] blue;
    logic pix_valid_o;
    logic transparent_o;
    modport master (
        output wr_en, wr_bank, wr_index, wr_rgb, pix_valid_i, pix_index_i,
        input red, green, blue, pix_valid_o, transparent_o
    );
    modport slave (
        input wr_en, wr_bank, wr_index, wr_rgb, pix_valid_i, pix_index_i,
        output red, green, blue, pix_valid_o, transparent_o
    );
endinterface

// File: rtl/sprite_palette_bank.sv
// sprite_palette_bank: banked writable palette, 2-stage lookup with transparency key,
// frame-boundary bank switch and frame-paced brightness fade.
module sprite_palette_bank #(
    parameter int INDEX_W = 4,
    parameter int CHAN_W = 4,
    parameter int BANKS = 4,
    parameter int FADE_DIV = 2,
    localparam int BANK_W = BANKS > 1 ? $clog2(BANKS) : 1,
    localparam int LVL_W = CHAN_W + 1
) (
    input  logic Clk,
    input  logic Reset_n,
    sprite_palette_bank_if.slave bus,
    input  logic frame_start,
    input  logic [BANK_W-1:0] bank_sel,
    input  logic fade_start,
    input  logic [LVL_W-1:0] fade_target,
    output logic fade_busy,
    output logic fade_done,
    output logic [LVL_W-1:0] fade_level
);
    localparam int ENTRIES = 2 ** INDEX_W;
    localparam int RGB_W = 3 * CHAN_W;
    localparam int CNT_W = $clog2(FADE_DIV + 1);
    localparam logic [LVL_W-1:0] FULL = LVL_W'(1) << CHAN_W;

    typedef enum logic {IDLE, FADING} state_t;

    logic [RGB_W-1:0] mem [BANKS][ENTRIES];
    logic [BANK_W-1:0] active;
    logic [RGB_W-1:0] s1_rgb;
    logic s1_valid;
    logic s1_trans;
    state_t state;
    logic [LVL_W-1:0] target;
    logic [LVL_W-1:0] clamped;
    logic [LVL_W-1:0] next_level;
    logic [CNT_W-1:0] cnt;

    function automatic logic [CHAN_W-1:0] scale(input logic [CHAN_W-1:0] c, input logic [LVL_W-1:0] lvl);
        return CHAN_W'(((2 * CHAN_W)'(c) * (2 * CHAN_W)'(lvl)) >> CHAN_W);
    endfunction

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int b = 0; b < BANKS; b++)
                for (int e = 0; e < ENTRIES; e++)
                    mem[b][e] <= '0;
            active <= '0;
        end else begin
            if (bus.wr_en && 32'(bus.wr_bank) < BANKS)
                mem[bus.wr_bank][bus.wr_index] <= bus.wr_rgb;
            if (frame_start && 32'(bus_sel_ok(bank_sel)) != 0)
                active <= bank_sel;
        end
    end

    function automatic logic bus_sel_ok(input logic [BANK_W-1:0] b);
        return 32'(b) < BANKS;
    endfunction

    // Stage 1 reads through the old memory contents, so a same-cycle write is seen one lookup later.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            s1_rgb <= '0;
            s1_valid <= 1'b0;
            s1_trans <= 1'b0;
            bus.red <= '0;
            bus.green <= '0;
            bus.blue <= '0;
            bus.pix_valid_o <= 1'b0;
            bus.transparent_o <= 1'b0;
        end else begin
            s1_rgb <= mem[active][bus.pix_index_i];
            s1_valid <= bus.pix_valid_i;
            s1_trans <= bus.pix_index_i == '0;
            bus.red <= scale(s1_rgb[RGB_W-1 -: CHAN_W], fade_level);
            bus.green <= scale(s1_rgb[2*CHAN_W-1 -: CHAN_W], fade_level);
            bus.blue <= scale(s1_rgb[CHAN_W-1:0], fade_level);
            bus.pix_valid_o <= s1_valid;
            bus.transparent_o <= s1_valid & s1_trans;
        end
    end

    always_comb begin
        clamped = fade_target > FULL ? FULL : fade_target;
        next_level = fade_level < target ? fade_level + LVL_W'(1) : fade_level - LVL_W'(1);
    end

    // fade_start takes priority, so a coincident frame_start never advances the counter.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
            target <= FULL;
            cnt <= '0;
            fade_level <= FULL;
            fade_done <= 1'b0;
        end else begin
            fade_done <= 1'b0;
            if (fade_start) begin
                target <= clamped;
                cnt <= '0;
                state <= clamped != fade_level ? FADING : IDLE;
                fade_done <= clamped == fade_level;
            end else if (state == FADING && frame_start) begin
                if (cnt == CNT_W'(FADE_DIV - 1)) begin
                    cnt <= '0;
                    fade_level <= next_level;
                    if (next_level == target) begin
                        state <= IDLE;
                        fade_done <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign fade_busy = state == FADING;
endmodule

// File: tb/tb_sprite_palette_bank.sv
// tb_sprite_palette_bank: directed stimulus with a lookup scoreboard checked by a decoupled monitor.
module tb_sprite_palette_bank;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic frame_start = 1'b0;
    logic [1:0] bank_sel = 2'd0;
    logic fade_start = 1'b0;
    logic [4:0] fade_target = 5'd0;
    logic fade_busy;
    logic fade_done;
    logic [4:0] fade_level;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ndone = 0;

    typedef struct {
        logic [11:0] rgb;
        logic tr;
        int cyc;
    } exp_t;
    exp_t q[$];

    sprite_palette_bank_if #(.INDEX_W(4), .CHAN_W(4), .BANKS(4)) bus();

    sprite_palette_bank #(.INDEX_W(4), .CHAN_W(4), .BANKS(4), .FADE_DIV(2)) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .bus(bus),
        .frame_start(frame_start),
        .bank_sel(bank_sel),
        .fade_start(fade_start),
        .fade_target(fade_target),
        .fade_busy(fade_busy),
        .fade_done(fade_done),
        .fade_level(fade_level)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;
    always @(negedge Clk) if (fade_done === 1'b1) ndone++;

    always @(negedge Clk) begin : monitor
        exp_t e;
        if (bus.pix_valid_o === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got rgb=%h tr=%b with no pending lookup",
                         {bus.red, bus.green, bus.blue}, bus.transparent_o);
            end else begin
                e = q.pop_front();
                if ({bus.red, bus.green, bus.blue} !== e.rgb || bus.transparent_o !== e.tr || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL lookup got rgb=%h tr=%b cyc=%0d expected rgb=%h tr=%b cyc=%0d",
                             {bus.red, bus.green, bus.blue}, bus.transparent_o, cyc, e.rgb, e.tr, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] b, input logic [3:0] idx, input logic [11:0] rgb);
        bus.wr_en = 1'b1;
        bus.wr_bank = b;
        bus.wr_index = idx;
        bus.wr_rgb = rgb;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic look(input logic [3:0] idx, input logic [11:0] rgb, input logic tr);
        exp_t e;
        bus.pix_valid_i = 1'b1;
        bus.pix_index_i = idx;
        e.rgb = rgb;
        e.tr = tr;
        e.cyc = cyc + 2;
        q.push_back(e);
        tick();
        bus.pix_valid_i = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_bank = '0;
        bus.wr_index = '0;
        bus.wr_rgb = '0;
        bus.pix_valid_i = 1'b0;
        bus.pix_index_i = '0;
        repeat (3) tick();
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("reset_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h0);
        chk("reset_valid", 32'(bus.pix_valid_o), 32'd0);
        chk("reset_transp", 32'(bus.transparent_o), 32'd0);
        chk("reset_busy", 32'(fade_busy), 32'd0);
        chk("reset_done", 32'(fade_done), 32'd0);
        chk("reset_level", 32'(fade_level), 32'd16);
        tick();
        wr(2'd0, 4'd3, 12'h39D);
        look(4'd3, 12'h39D, 1'b0);
        look(4'd0, 12'h000, 1'b1);
        wr(2'd2, 4'd5, 12'hC65);
        look(4'd5, 12'h000, 1'b0);
        bank_sel = 2'd2;
        tick();
        look(4'd5, 12'h000, 1'b0);
        frame_start = 1'b1;
        look(4'd5, 12'h000, 1'b0);
        frame_start = 1'b0;
        look(4'd5, 12'hC65, 1'b0);
        bus.wr_en = 1'b1;
        bus.wr_bank = 2'd2;
        bus.wr_index = 4'd7;
        bus.wr_rgb = 12'hABC;
        look(4'd7, 12'h000, 1'b0);
        bus.wr_en = 1'b0;
        look(4'd7, 12'hABC, 1'b0);
        for (int i = 1; i < 16; i++) wr(2'd2, 4'(i), 12'(i * 12'h111));
        for (int i = 1; i < 16; i++) look(4'(i), 12'(i * 12'h111), 1'b0);
        repeat (3) tick();
        wr(2'd2, 4'd4, 12'hE84);
        fade_target = 5'd8;
        fade_start = 1'b1;
        tick();
        fade_start = 1'b0;
        @(negedge Clk);
        chk("fade_busy_start", 32'(fade_busy), 32'd1);
        chk("fade_level_start", 32'(fade_level), 32'd16);
        repeat (2) frame();
        @(negedge Clk);
        chk("fade_level_2f", 32'(fade_level), 32'd15);
        repeat (13) frame();
        @(negedge Clk);
        chk("fade_level_15f", 32'(fade_level), 32'd9);
        chk("fade_busy_15f", 32'(fade_busy), 32'd1);
        frame();
        @(negedge Clk);
        chk("fade_level_16f", 32'(fade_level), 32'd8);
        chk("fade_busy_16f", 32'(fade_busy), 32'd0);
        chk("fade_done_once", 32'(ndone), 32'd1);
        tick();
        look(4'd4, 12'h742, 1'b0);
        repeat (3) tick();
        fade_start = 1'b1;
        tick();
        fade_start = 1'b0;
        @(negedge Clk);
        chk("fade_equal_done", 32'(fade_done), 32'd1);
        chk("fade_equal_busy", 32'(fade_busy), 32'd0);
        tick();
        fade_target = 5'd20;
        fade_start = 1'b1;
        frame_start = 1'b1;
        tick();
        fade_start = 1'b0;
        frame_start = 1'b0;
        @(negedge Clk);
        chk("coincident_busy", 32'(fade_busy), 32'd1);
        tick();
        frame();
        @(negedge Clk);
        chk("coincident_no_count", 32'(fade_level), 32'd8);
        tick();
        frame();
        @(negedge Clk);
        chk("clamped_step_up", 32'(fade_level), 32'd9);
        tick();
        bus.pix_valid_i = 1'b1;
        bus.pix_index_i = 4'd4;
        tick();
        bus.pix_valid_i = 1'b0;
        Reset_n = 1'b0;
        tick();
        @(negedge Clk);
        chk("midreset_valid", 32'(bus.pix_valid_o), 32'd0);
        chk("midreset_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h0);
        chk("midreset_level", 32'(fade_level), 32'd16);
        chk("midreset_busy", 32'(fade_busy), 32'd0);
        chk("midreset_done", 32'(fade_done), 32'd0);
        tick();
        Reset_n = 1'b1;
        repeat (2) tick();
        wr(2'd2, 4'd2, 12'h456);
        look(4'd2, 12'h000, 1'b0);
        look(4'd3, 12'h000, 1'b0);
        repeat (4) tick();
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_palette_bank.md
# sprite_palette_bank

Writable, multi-bank successor to the fixed 16-entry sprite palette ROMs. It maps a per-pixel colour index to 12-bit RGB through a 2-stage registered pipeline and flags the transparency key (index 0). Palette contents are loaded at run time, the active bank switches only on frame boundaries, and a frame-paced brightness fade is applied. It sits between the sprite/tile pixel fetchers and the VGA colour mapper.

## Interface
- INDEX_W, 4, colour index width; entries per bank = 2**INDEX_W
- CHAN_W, 4, bits per colour channel
- BANKS, 4, number of palette banks; BANK_W = max(1, $clog2(BANKS))
- FADE_DIV, 2, frames per fade step (>= 1)

- Clk  in  1  sole clock
- Reset_n  in  1  synchronous, active-low reset
- frame_start  in  1  one-cycle pulse at the start of each frame (vsync)
- bank_sel  in  BANK_W  requested bank, sampled only on frame_start
- wr_en  in  1  write strobe for a palette entry
- wr_bank  in  BANK_W  bank to write
- wr_index  in  INDEX_W  entry to write
- wr_rgb  in  3*CHAN_W  {R,G,B} value to write
- pix_valid_i  in  1  lookup request
- pix_index_i  in  INDEX_W  colour index to look up
- fade_start  in  1  one-cycle pulse that begins a fade
- fade_target  in  CHAN_W+1  target brightness, 0..2**CHAN_W
- red, green, blue  out  CHAN_W each  scaled colour
- pix_valid_o  out  1  output valid, pix_valid_i delayed 2 cycles
- transparent_o  out  1  set when the looked-up index was 0
- fade_busy  out  1  fade in progress
- fade_done  out  1  one-cycle pulse when the fade reaches its target
- fade_level  out  CHAN_W+1  current brightness

## Operation
- Storage: BANKS × 2**INDEX_W × 3*CHAN_W registers. Reset clears every entry to 0.
- Writes: when wr_en=1, {wr_bank, wr_index} is written at the clock edge. Any bank may be written at any time, including the active bank.
- Write indices must be < BANKS. Out-of-range writes are ignored.
- Active bank: register reset to 0. Loads bank_sel on frame_start. Out-of-range bank_sel is ignored and the active bank is kept.
- Lookup stage 1: registers the raw entry from the active bank, the valid bit, and (pix_index_i == 0).
- Lookup stage 2: registers each channel as (c × fade_level) >> CHAN_W, which is exact at fade_level = 2**CHAN_W. It also registers the valid and transparent bits.
- When valid is 0, the colour outputs are don't-care. transparent_o is gated by the valid bit.
- Fade FSM states are IDLE and FADING:
  - fade_start in any state: latch the target, clamped to 2**CHAN_W, and clear the frame counter. Go to FADING when target ≠ fade_level. Otherwise stay in or return to IDLE and pulse fade_done on the next cycle.
  - FADING: each frame_start increments the frame counter. When the count reaches FADE_DIV, fade_level steps by 1 toward the target and the counter clears.
  - When the step makes fade_level equal to the target, go to IDLE and pulse fade_done for 1 cycle.
  - fade_busy = (state == FADING).
- fade_start and frame_start in the same cycle: fade_start wins, and that frame produces no count.

## Timing
- Reset values: red = green = blue = 0, pix_valid_o = 0, transparent_o = 0, fade_busy = 0, fade_done = 0, fade_level = 2**CHAN_W. The active bank resets to 0.
- Lookup latency is 2 cycles, with throughput of 1 per cycle and no stalls.
- Write and lookup of the same entry in the same cycle: the lookup returns the old value. A lookup in the next cycle returns the new value.
- The bank switch applies to lookups presented in the cycle after frame_start. Lookups already in the pipeline complete with the old bank.
- fade_level changes the cycle after the qualifying frame_start. The new level applies to the stage-2 result registered on the following edge.
- Reset asserted mid-fade or mid-pipeline: all state returns to reset values on that edge, and pipeline contents are discarded.

## Test plan
- Write bank 0 idx 3 = 0x39D, then look up idx 3 → 0x39D with pix_valid_o exactly 2 cycles later. Look up idx 0 → transparent_o = 1.
- Write bank 2 idx 5 = 0xC65 while bank 0 is active: lookup returns 0x000. Set bank_sel = 2 without frame_start → still 0x000. Pulse frame_start → next lookup returns 0xC65.
- Same-cycle write of 0xABC to idx 7 and lookup of idx 7 → old value. Lookup on the next cycle → 0xABC.
- Back-to-back lookups for idx 1..15 on consecutive cycles → 15 consecutive valid outputs in order, with no gaps.
- With CHAN_W=4, FADE_DIV=2, entry 0xE84: fade_start with target 8 → fade_level reaches 8 after 16 frame_starts, and fade_done pulses once. Colour output = 0x742.
- fade_start and frame_start in the same cycle, followed by Reset_n low mid-fade → the coincident frame produces no count. The reset returns fade_level to 16, fade_busy to 0, and outputs to 0.
